// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
//   shift_op_e : operation select as presented on the op port
//   state_e    : sequencer FSM states
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_RSVD = 2'b10,  // passes the operand through untouched
        OP_SRA  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One partial shift step, purely combinational.
// Ports:
//   data_i  in  XLEN  value to shift
//   op_i    in  2     operation (shift_op_e)
//   k_i     in  KW    shift distance, 0..STEP
//   data_o  out XLEN  shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int STEP = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] data_i,
    input  shift_op_e       op_i,
    input  logic [KW-1:0]   k_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << k_i;
            OP_SRL:  data_o = data_i >> k_i;
            // Accumulator MSB is still the original sign bit, so an arithmetic
            // shift of the partial result keeps replicating it.
            OP_SRA:  data_o = $signed(data_i) >>> k_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: one op in flight, shifts up to STEP bits
// per cycle until shamt is consumed, then holds the result for writeback.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      abort any in-flight op (result kept)
//   start_valid/start_ready    issue handshake; op/operand/shamt sampled on accept
//   result_valid/result_ready  writeback handshake; result held while valid
//   busy                       op in RUN or DONE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [1:0]              op,
    input  logic [XLEN-1:0]         operand,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [XLEN-1:0]         result,
    output logic                    busy
);

    localparam int SW = $clog2(XLEN);
    localparam int KW = $clog2(STEP + 1);

    state_e          state_q, state_d;
    shift_op_e       op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SW-1:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            start_ready_q, start_ready_d;
    logic            result_valid_q, result_valid_d;
    logic            busy_q, busy_d;

    logic [KW-1:0]   k;
    logic [XLEN-1:0] step_out;

    // k = min(STEP, remaining); k never exceeds remaining so the counter cannot wrap
    always_comb begin
        if (32'(rem_q) >= STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
    end

    shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
        .data_i (acc_q),
        .op_i   (op_q),
        .k_i    (k),
        .data_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    op_d  = shift_op_e'(op);
                    acc_d = operand;
                    rem_d = shamt;
                    // Nothing to shift: finish in one cycle with the operand as-is
                    if (shamt == '0 || shift_op_e'(op) == OP_RSVD) begin
                        state_d  = DONE;
                        result_d = operand;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step_out;
                rem_d = rem_q - SW'(k);
                if (rem_d == '0) begin
                    state_d  = DONE;
                    result_d = step_out;
                end
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides accept and retire; the last delivered result stays visible
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_SLL;
            acc_q          <= '0;
            rem_q          <= '0;
            result_q       <= '0;
            start_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            rem_q          <= rem_d;
            result_q       <= result_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (XLEN=32, STEP=4): a vector table of
// single ops with expected result and latency, plus hand-written sequences
// for back-pressure, flush and mid-operation reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [4:0]  shamt = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.XLEN(32), .STEP(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .operand      (operand),
        .shamt        (shamt),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an op in the cycle after the next edge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        @(posedge clk); #1;
        chk("start_ready before issue", {31'b0, start_ready}, 32'd1);
        start_valid = 1'b1; op = o; operand = d; shamt = s;
        @(posedge clk); #1;
        // Garbage after the accept cycle must be ignored
        start_valid = 1'b0; op = 2'b10; operand = 32'hDEAD_BEEF; shamt = 5'd7;
    endtask

    // Counts cycles from accept (cycle 0) until result_valid; 99 on timeout.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (result_valid) return;
            @(posedge clk); #1;
            lat++;
        end
        lat = 99;
        $display("FAIL wait_valid: timeout, result_valid never rose");
    endtask

    task automatic retire();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("retire result_valid", {31'b0, result_valid}, 32'd0);
        chk("retire start_ready", {31'b0, start_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, 3};
        vecs[1]  = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
        vecs[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9};
        vecs[3]  = '{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[4]  = '{2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[5]  = '{2'b10, 32'hCAFE_F00D, 5'd17, 32'hCAFE_F00D, 1};
        vecs[6]  = '{2'b00, 32'h0000_000F, 5'd4,  32'h0000_00F0, 2};
        vecs[7]  = '{2'b11, 32'h1234_5678, 5'd8,  32'h0012_3456, 3};
        vecs[8]  = '{2'b11, 32'hF000_0000, 5'd3,  32'hFE00_0000, 2};
        vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 9};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 5};
        vecs[11] = '{2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000, 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset result_valid", {31'b0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset start_ready", {31'b0, start_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("start_ready after release", {31'b0, start_ready}, 32'd1);

        // Table of single ops
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].operand, vecs[i].shamt);
            wait_valid(lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d result", i), result, vecs[i].res);
            retire();
        end

        // Back-pressure: result held for 3 cycles while an extra start is offered
        issue(2'b00, 32'h0000_000F, 5'd4);
        wait_valid(lat);
        chk("bp latency", 32'(lat), 32'd2);
        start_valid = 1'b1; op = 2'b00; operand = 32'h1; shamt = 5'd1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            chk("bp result", result, 32'h0000_00F0);
            chk("bp result_valid", {31'b0, result_valid}, 32'd1);
            chk("bp start_ready", {31'b0, start_ready}, 32'd0);
            chk("bp busy", {31'b0, busy}, 32'd1);
        end
        start_valid = 1'b0;
        retire();
        chk("bp busy after retire", {31'b0, busy}, 32'd0);

        // Flush in RUN cycle 2 of SRA shamt=16
        issue(2'b11, 32'h8000_0000, 5'd16);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush start_ready", {31'b0, start_ready}, 32'd1);
        chk("flush busy", {31'b0, busy}, 32'd0);
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (result_valid) lat++;
        end
        chk("flush result_valid never", 32'(lat), 32'd0);
        chk("flush result unchanged", result, 32'h0000_00F0);
        issue(2'b01, 32'h0000_0100, 5'd8);
        wait_valid(lat);
        chk("post-flush latency", 32'(lat), 32'd3);
        chk("post-flush result", result, 32'h0000_0001);
        retire();

        // Flush beats start in IDLE
        @(posedge clk); #1;
        flush = 1'b1; start_valid = 1'b1; op = 2'b00; operand = 32'h5; shamt = 5'd2;
        @(posedge clk); #1;
        flush = 1'b0; start_valid = 1'b0;
        chk("flush+start busy", {31'b0, busy}, 32'd0);
        chk("flush+start start_ready", {31'b0, start_ready}, 32'd1);

        // Flush in DONE: valid drops, result kept
        issue(2'b00, 32'h0000_0003, 5'd0);
        @(negedge clk);
        chk("done result", result, 32'h0000_0003);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("done flush result_valid", {31'b0, result_valid}, 32'd0);
        chk("done flush result kept", result, 32'h0000_0003);

        // One-cycle reset mid-RUN
        issue(2'b00, 32'h0000_0001, 5'd20);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst result_valid", {31'b0, result_valid}, 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("midrst start_ready", {31'b0, start_ready}, 32'd1);
        issue(2'b00, 32'h0000_0001, 5'd20);
        wait_valid(lat);
        chk("post-reset latency", 32'(lat), 32'd6);
        chk("post-reset result", result, 32'h0010_0000);
        retire();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
